// File: rtl/pfg_pout_ctrl.sv
// Post-accumulation output controller: skips all but the last of N accumulated
// FFT frames, then serialises each 16-bit word of the final frame as two bytes.
module pfg_pout_ctrl #(
  parameter int FFT_SIZE = 512,
  parameter int FRM_W    = 8
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             start,
  input  logic [FRM_W-1:0] acc_frames,
  output logic             acc_clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy,
  output logic             done,
  output logic             err_len
);

  localparam int                WCNT_W    = $clog2(FFT_SIZE);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(FFT_SIZE - 1);
  localparam logic [FRM_W-1:0]  FRM_ONE   = FRM_W'(1);

  typedef enum logic [2:0] {IDLE, CLR, SKIP, DRAIN, FLUSH} state_t;

  state_t            state;
  logic [FRM_W-1:0]  frm_left;
  logic [WCNT_W-1:0] wcnt;
  logic [15:0]       hold_p1;
  logic              vld_p1;
  logic              sel_hi_p1;

  logic in_hs;
  logic out_hs;
  logic len_bad;

  function automatic logic [FRM_W-1:0] frames_min1(input logic [FRM_W-1:0] f);
    return (f == '0) ? FRM_ONE : f;
  endfunction

  // Frame countdown saturates at 1 so a malformed stream can never wrap it.
  function automatic logic [FRM_W-1:0] sat_dec(input logic [FRM_W-1:0] f);
    return (f > FRM_ONE) ? (f - FRM_ONE) : FRM_ONE;
  endfunction

  always_comb begin
    in_ready = 1'b0;
    case (state)
      SKIP:    in_ready = 1'b1;
      DRAIN:   in_ready = !vld_p1 || (sel_hi_p1 && out_ready);
      default: in_ready = 1'b0;
    endcase
  end

  assign in_hs     = in_valid && in_ready;
  assign out_hs    = vld_p1 && out_ready;
  assign out_valid = vld_p1;
  assign out_data  = sel_hi_p1 ? hold_p1[15:8] : hold_p1[7:0];
  assign len_bad   = in_last ? (wcnt != WCNT_LAST) : (wcnt == WCNT_LAST);

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state     <= IDLE;
      frm_left  <= '0;
      wcnt      <= '0;
      hold_p1   <= '0;
      vld_p1    <= 1'b0;
      sel_hi_p1 <= 1'b0;
      acc_clear <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      acc_clear <= 1'b0;
      done      <= 1'b0;

      // Length check runs on every accepted word; the frame boundary always follows in_last.
      if (in_hs) begin
        wcnt <= in_last ? '0 : (wcnt + WCNT_W'(1));
        if (len_bad) err_len <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            frm_left  <= frames_min1(acc_frames);
            err_len   <= 1'b0;
            acc_clear <= 1'b1;
            busy      <= 1'b1;
            state     <= CLR;
          end
        end

        CLR: begin
          wcnt  <= '0;
          state <= (frm_left > FRM_ONE) ? SKIP : DRAIN;
        end

        SKIP: begin
          if (in_hs && in_last) begin
            frm_left <= sat_dec(frm_left);
            if (sat_dec(frm_left) == FRM_ONE) state <= DRAIN;
          end
        end

        // Byte serialiser: low byte then high byte; a new word may load on the high-byte handshake.
        DRAIN, FLUSH: begin
          if (out_hs) begin
            if (sel_hi_p1) begin
              vld_p1    <= 1'b0;
              sel_hi_p1 <= 1'b0;
              if (state == FLUSH) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              sel_hi_p1 <= 1'b1;
            end
          end
          if (in_hs) begin
            hold_p1   <= in_data;
            vld_p1    <= 1'b1;
            sel_hi_p1 <= 1'b0;
            if (in_last) state <= FLUSH;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pfg_pout_ctrl.sv
// Directed bench for pfg_pout_ctrl with a byte scoreboard fed by accepted DRAIN words.
module tb_pfg_pout_ctrl;

  logic        clock;
  logic        resetb;
  logic        start;
  logic [7:0]  acc_frames;
  logic        acc_clear;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;
  logic        done;
  logic        err_len;

  pfg_pout_ctrl #(.FFT_SIZE(4), .FRM_W(8)) dut (
    .clock      (clock),
    .resetb     (resetb),
    .start      (start),
    .acc_frames (acc_frames),
    .acc_clear  (acc_clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .err_len    (err_len)
  );

  int checks    = 0;
  int errors    = 0;
  int clr_cnt   = 0;
  int done_cnt  = 0;
  int ov_skip   = 0;
  int nbytes    = 0;
  int ready_mode = 0;
  logic skip_phase = 1'b0;
  logic [7:0] expq[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // out_ready driver: 0 = always ready, 1 = random 50%, 2 = stalled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pops, stall stability, pulse counters.
  initial begin
    logic       hold_prev;
    logic [7:0] prev_data;
    logic [7:0] eb;
    hold_prev = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clock);
      if (!resetb) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) check("stall_stable", {23'd0, out_valid, out_data}, {23'd0, 1'b1, prev_data});
        if (acc_clear) clr_cnt++;
        if (done) done_cnt++;
        if (skip_phase && out_valid) ov_skip++;
        if (out_valid && out_ready) begin
          nbytes++;
          check("byte_expected", (expq.size() != 0), 1);
          if (expq.size() != 0) begin
            eb = expq.pop_front();
            check("byte_value", out_data, eb);
          end
        end
        hold_prev = out_valid && !out_ready;
        prev_data = out_data;
      end
    end
  end

  task automatic check_zero(input string pfx);
    check({pfx, "_out_valid"}, out_valid, 0);
    check({pfx, "_out_data"},  out_data,  0);
    check({pfx, "_in_ready"},  in_ready,  0);
    check({pfx, "_acc_clear"}, acc_clear, 0);
    check({pfx, "_done"},      done,      0);
    check({pfx, "_busy"},      busy,      0);
    check({pfx, "_err_len"},   err_len,   0);
  endtask

  task automatic do_reset(input string pfx);
    resetb = 1'b0;
    @(posedge clock); #1;
    check_zero({pfx, "_inrst"});
    resetb = 1'b1;
    @(posedge clock); #1;
    check_zero({pfx, "_postrst"});
  endtask

  task automatic pulse_start(input logic [7:0] frames);
    @(posedge clock); #1;
    start = 1'b1;
    acc_frames = frames;
    @(posedge clock); #1;
    start = 1'b0;
    check("start_acc_clear", acc_clear, 1);
    check("start_busy", busy, 1);
  endtask

  task automatic send_word(input logic [15:0] d, input logic last, input logic drain);
    logic hs;
    hs = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clock);
      hs = in_ready;
      @(posedge clock); #1;
    end
    check("in_handshake", hs, 1);
    if (hs && drain) begin
      expq.push_back(d[7:0]);
      expq.push_back(d[15:8]);
      check("first_byte_latency", out_valid, 1);
    end
  endtask

  task automatic send_frame(input logic [15:0] w0, w1, w2, w3, input logic drain);
    send_word(w0, 1'b0, drain);
    send_word(w1, 1'b0, drain);
    send_word(w2, 1'b0, drain);
    send_word(w3, 1'b1, drain);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clock);
      got = done;
    end
    check("done_seen", got, 1);
    if (got) check("busy_at_done", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetb     = 1'b0;
    start      = 1'b0;
    acc_frames = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;

    do_reset("init");

    // Single frame, always ready
    done_cnt = 0;
    pulse_start(8'd1);
    send_frame(16'h1234, 16'hABCD, 16'h0001, 16'hFF00, 1'b1);
    wait_done();
    repeat (3) @(posedge clock);
    #1;
    check("t1_done_once", done_cnt, 1);
    check("t1_queue_empty", expq.size(), 0);
    check("t1_busy_idle", busy, 0);

    // Three accumulated frames: only the last one drains
    clr_cnt = 0;
    ov_skip = 0;
    pulse_start(8'd3);
    skip_phase = 1'b1;
    send_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0);
    send_frame(16'h5555, 16'h6666, 16'h7777, 16'h8888, 1'b0);
    skip_phase = 1'b0;
    send_frame(16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718, 1'b1);
    wait_done();
    check("t2_no_out_in_skip", ov_skip, 0);
    check("t2_one_clear", clr_cnt, 1);
    check("t2_queue_empty", expq.size(), 0);

    // Random backpressure with continuous input
    ready_mode = 1;
    pulse_start(8'd1);
    send_frame(16'h1234, 16'hABCD, 16'h0001, 16'hFF00, 1'b1);
    wait_done();
    ready_mode = 0;
    check("t3_queue_empty", expq.size(), 0);

    // Short frame: in_last on the third word
    pulse_start(8'd1);
    send_word(16'h0A0B, 1'b0, 1'b1);
    send_word(16'h0C0D, 1'b0, 1'b1);
    send_word(16'h0E0F, 1'b1, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_done();
    check("t4_err_len_set", err_len, 1);
    pulse_start(8'd1);
    check("t4_err_len_cleared", err_len, 0);
    send_frame(16'h1357, 16'h2468, 16'h9BDF, 16'hACE0, 1'b1);
    wait_done();
    check("t4_err_len_clean", err_len, 0);

    // Reset after three bytes of DRAIN
    pulse_start(8'd1);
    nbytes = 0;
    send_word(16'h5A3C, 1'b0, 1'b1);
    send_word(16'h7E81, 1'b0, 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 100 && nbytes < 3; i++) @(posedge clock);
    #1;
    check("t5_three_bytes", nbytes, 3);
    do_reset("midrun");
    expq.delete();
    pulse_start(8'd1);
    send_frame(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 1'b1);
    wait_done();
    check("t5_queue_empty", expq.size(), 0);

    // acc_frames=0 behaves as 1; start while busy is ignored
    clr_cnt  = 0;
    done_cnt = 0;
    pulse_start(8'd0);
    send_word(16'h4321, 1'b0, 1'b1);
    in_valid = 1'b0;
    start = 1'b1;
    acc_frames = 8'd2;
    @(posedge clock); #1;
    start = 1'b0;
    check("t6_busy_held", busy, 1);
    send_word(16'h8765, 1'b0, 1'b1);
    send_word(16'hCBA9, 1'b0, 1'b1);
    send_word(16'h0FED, 1'b1, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_done();
    repeat (6) @(posedge clock);
    #1;
    check("t6_done_once", done_cnt, 1);
    check("t6_clear_once", clr_cnt, 1);
    check("t6_idle", busy, 0);
    check("t6_queue_empty", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pfg_pout_ctrl.md
PFG_POUT_CTRL -- requirements
Module: pfg_pout_ctrl

Interface
REQ-001 SHALL have parameter FFT_SIZE, default 512, meaning words per FFT frame (power of two, 4..4096).
REQ-002 SHALL have parameter FRM_W, default 8, meaning width of the frame-count configuration.
REQ-003 SHALL have port clock, input, 1, meaning the single clock for all logic.
REQ-004 SHALL have port resetb, input, 1, meaning reset; reset is synchronous and active-low.
REQ-005 SHALL have port start, input, 1, meaning a pulse that begins one accumulate-and-drain run.
REQ-006 SHALL have port acc_frames, input, FRM_W, meaning frames per run; 0 is treated as 1.
REQ-007 SHALL have port acc_clear, output, 1, meaning a one-cycle clear pulse to the accumulator.
REQ-008 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, 16) and in_last (input, 1), meaning the accumulator output stream.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, 8), meaning the byte stream to the pads.
REQ-010 SHALL have ports busy (output, 1), done (output, 1) and err_len (output, 1), meaning status.

Function
REQ-011 SHALL implement states IDLE, CLR, SKIP, DRAIN and FLUSH.
REQ-012 IDLE: start=1 SHALL latch acc_frames into frm_left and go to CLR; start SHALL be ignored in all other states.
REQ-013 CLR: acc_clear=1 for exactly one cycle; next state is SKIP if frm_left>1, else DRAIN.
REQ-014 SKIP: in_ready=1 and out_valid=0; accepted words SHALL be discarded.
REQ-015 SKIP: a handshake with in_last=1 SHALL decrement frm_left; the state SHALL become DRAIN when the decremented value equals 1.
REQ-016 DRAIN: each accepted word SHALL be loaded into a 16-bit hold register with hold_valid=1 and byte select lo.
REQ-017 Bytes SHALL be emitted as out_data = low byte, then high byte; out_valid=hold_valid.
REQ-018 Byte select SHALL advance only on the out_valid&&out_ready handshake.
REQ-019 After the high-byte handshake, hold_valid SHALL clear unless a new word is loaded in the same cycle.
REQ-020 DRAIN: in_ready = !hold_valid || (sel==hi && out_ready).
- This gives full throughput: one word every 2 cycles.
- There is no combinational path from in_valid to out_valid.
REQ-021 Word counter wcnt, width log2(FFT_SIZE):
- SHALL clear on CLR;
- SHALL increment on each input handshake in SKIP and DRAIN;
- SHALL wrap to 0 on in_last handshakes.
REQ-022 An in_last handshake with wcnt != FFT_SIZE-1 SHALL set err_len, as SHALL wcnt == FFT_SIZE-1 without in_last.
- err_len is sticky until the next start accepted in IDLE.
- On such an error the frame boundary SHALL still follow in_last.
REQ-023 DRAIN: the in_last word handshake SHALL move the state to FLUSH, with in_ready=0 in FLUSH.
REQ-024 FLUSH: the high-byte handshake of the last word SHALL pulse done for 1 cycle and return the state to IDLE.
REQ-025 busy=1 in every state except IDLE.
REQ-026 Latency: the first out_valid SHALL assert exactly 1 cycle after the first DRAIN input handshake.
REQ-027 Holding out_ready=0 SHALL keep out_data and out_valid stable indefinitely.
REQ-028 frm_left SHALL be a FRM_W-bit register and SHALL never wrap below 1.

Reset
REQ-029 While resetb=0 at a clock edge, the state SHALL be IDLE and the following SHALL all be 0:
- in_ready, acc_clear, done, busy and err_len;
- out_valid and out_data;
- hold register, wcnt and frm_left.
REQ-030 Reset asserted mid-run SHALL abort the run, discarding any held bytes without emitting them.
REQ-031 No output SHALL be driven from non-reset state during the first cycle after resetb rises.

Verification
REQ-032 FFT_SIZE=4, acc_frames=1, input words 0x1234, 0xABCD, 0x0001, 0xFF00 with out_ready=1 -> bytes 34 12 CD AB 01 00 00 FF, then done=1 for 1 cycle and busy=0.
REQ-033 acc_frames=3, three 4-word frames with distinct values -> frames 1-2 are consumed with no out_valid, only frame 3 bytes appear, and acc_clear pulses once.
REQ-034 Random out_ready (50%) with in_valid always 1 -> the byte sequence is identical to REQ-032 and out_data never changes while out_valid=1 and out_ready=0.
REQ-035 in_last on the 3rd word with FFT_SIZE=4 -> err_len=1, FLUSH is entered and done pulses; a subsequent start clears err_len.
REQ-036 resetb=0 for 1 cycle after 3 bytes of DRAIN -> all outputs are 0 on the next cycle, and a fresh start produces a complete correct run.
REQ-037 acc_frames=0 -> behaves as 1; start while busy -> ignored, and only one done pulse occurs.
